qie_gbtx_framer: RTL and testbench

- Parametrised QIE-to-GBTX framer: captures one QIE sample set per bunch crossing (N_CH channels of ADC data, discriminator bits and CapID) and buffers it in a frame FIFO.
- Serialises each frame as 16-bit words, with a valid/ready handshake, towards a GBTX link encoder.
- Checks CapID rotation and counts frames dropped on overflow.
- Sits between the QIE receive/alignment logic and the GBTX output buffers of the readout-module FPGA; one instance drives one GBTX.

---
 rtl/qie_gbtx_framer.sv | 179 +++++++++++++++++
 tb/tb_qie_gbtx_framer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qie_gbtx_framer.sv
// qie_gbtx_framer: QIE sample-set capture, frame FIFO and 16-bit GBTX word serializer (define QIE_FRAMER_CRC_EN for a trailing CRC-16 word)
module qie_gbtx_framer #(
    parameter int N_CH       = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     MClk,
    input  logic                     BkPln_RST_N,
    input  logic                     in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_disc,
    input  logic [1:0]               in_capid,
    input  logic                     in_bc0,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sof,
    output logic                     out_eof,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              capid_err_cnt
);
    localparam int DW = N_CH * DATA_W;
    localparam int NW = DW / 16;
    localparam int FW = 16 + DW + N_CH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DISC, S_CRC} state_t;
    state_t state, state_nx;

    logic            s_valid, s_bc0;
    logic [1:0]      s_capid;
    logic [DW-1:0]   s_data;
    logic [N_CH-1:0] s_disc;
    logic            ref_vld, drop_flag, capid_err;
    logic [1:0]      prev_capid;
    logic [2:0]      bx_cnt, bx_hdr;
    logic [15:0]     hdr, tail;
    logic [FW-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            empty, full, push, pop, adv;
    logic [15:0]     cur_hdr;
    logic [DW-1:0]   cur_data;
    logic [N_CH-1:0] cur_disc;
    logic [XW-1:0]   widx;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign capid_err = ref_vld && (s_capid != prev_capid + 2'd1);
    assign bx_hdr    = s_bc0 ? 3'd0 : bx_cnt;
    assign hdr       = {8'hBC, s_bc0, capid_err, drop_flag, s_capid, bx_hdr};
    assign push      = s_valid && (!full || pop);
    assign adv       = out_valid && out_ready;

    // register the incoming sample set; all bookkeeping runs one cycle later
    always_ff @(posedge MClk or negedge BkPln_RST_N) begin
        if (!BkPln_RST_N) begin
            s_valid <= 1'b0;
            s_bc0   <= 1'b0;
            s_capid <= '0;
            s_data  <= '0;
            s_disc  <= '0;
        end else begin
            s_valid <= in_valid;
            s_bc0   <= in_bc0 && in_valid;
            s_capid <= in_capid;
            s_data  <= in_data;
            s_disc  <= in_disc;
        end
    end

    // CapID reference, bunch counter, sticky drop flag and saturating error counters
    always_ff @(posedge MClk or negedge BkPln_RST_N) begin
        if (!BkPln_RST_N) begin
            ref_vld       <= 1'b0;
            prev_capid    <= '0;
            bx_cnt        <= '0;
            drop_flag     <= 1'b0;
            drop_cnt      <= '0;
            capid_err_cnt <= '0;
        end else if (s_valid) begin
            ref_vld    <= 1'b1;
            prev_capid <= s_capid;
            bx_cnt     <= bx_hdr + 3'd1;
            drop_flag  <= !push;
            if (!push) drop_cnt <= drop_cnt + 16'(drop_cnt != 16'hFFFF);
            if (capid_err) capid_err_cnt <= capid_err_cnt + 16'(capid_err_cnt != 16'hFFFF);
        end
    end

    // frame FIFO pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge MClk or negedge BkPln_RST_N) begin
        if (!BkPln_RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
        end
    end

    // frame storage, no reset needed since pointers guard every read
    always_ff @(posedge MClk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {hdr, s_data, s_disc};
    end

    // serializer state register
    always_ff @(posedge MClk or negedge BkPln_RST_N) begin
        if (!BkPln_RST_N) state <= S_IDLE;
        else state <= state_nx;
    end

    // serializer next state; leaving the last word reloads a header straight away when a frame waits
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                pop      = !empty;
                state_nx = empty ? S_IDLE : S_HDR;
            end
            S_HDR:  if (adv) state_nx = S_DATA;
            S_DATA: if (adv && widx == XW'(NW-1)) state_nx = S_DISC;
`ifdef QIE_FRAMER_CRC_EN
            S_DISC: if (adv) state_nx = S_CRC;
`endif
            default: if (adv) begin
                pop      = !empty;
                state_nx = empty ? S_IDLE : S_HDR;
            end
        endcase
    end

    // current frame held for the serializer, plus data word index
    always_ff @(posedge MClk or negedge BkPln_RST_N) begin
        if (!BkPln_RST_N) begin
            cur_hdr  <= '0;
            cur_data <= '0;
            cur_disc <= '0;
            widx     <= '0;
        end else begin
            if (pop) {cur_hdr, cur_data, cur_disc} <= mem[rd_ptr[AW-1:0]];
            widx <= (state == S_DATA) ? widx + XW'(adv) : '0;
        end
    end

`ifdef QIE_FRAMER_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // running CRC over accepted words, restarted whenever a new header is loaded
    always_ff @(posedge MClk or negedge BkPln_RST_N) begin
        if (!BkPln_RST_N) crc <= 16'hFFFF;
        else if (pop) crc <= 16'hFFFF;
        else if (adv && state != S_CRC) crc <= crc_step(crc, out_data);
    end

    assign tail    = (state == S_CRC) ? crc : 16'd0;
    assign out_eof = state == S_CRC;
`else
    assign tail    = 16'd0;
    assign out_eof = state == S_DISC;
`endif

    // word mux driven purely from registers so the word holds while stalled
    always_comb begin
        out_valid = state != S_IDLE;
        out_sof   = state == S_HDR;
        out_data  = (state == S_HDR)  ? cur_hdr :
                    (state == S_DATA) ? cur_data[16*int'(widx) +: 16] :
                    (state == S_DISC) ? 16'(cur_disc) : tail;
    end
endmodule

// File: tb/tb_qie_gbtx_framer.sv
// tb_qie_gbtx_framer: directed checks of framing, CapID, overflow, backpressure and reset (CRC word when QIE_FRAMER_CRC_EN is defined)
module tb_qie_gbtx_framer;
    localparam int N_CH = 12;
    localparam int DW   = 96;
    localparam int NW   = 6;
`ifdef QIE_FRAMER_CRC_EN
    localparam int NWORDS = NW + 3;
`else
    localparam int NWORDS = NW + 2;
`endif

    logic            MClk = 1'b0;
    logic            BkPln_RST_N = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic [N_CH-1:0] in_disc = '0;
    logic [1:0]      in_capid = '0;
    logic            in_bc0 = 1'b0;
    logic [15:0]     out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_sof;
    logic            out_eof;
    logic [15:0]     drop_cnt;
    logic [15:0]     capid_err_cnt;

    int n_chk = 0;
    int n_err = 0;
    int gaps  = 0;
    bit gap_watch = 1'b0;
    bit hold_prev = 1'b0;
    logic [31:0] held;
    logic [17:0] rxq[$];

    qie_gbtx_framer dut (
        .MClk(MClk), .BkPln_RST_N(BkPln_RST_N), .in_valid(in_valid), .in_data(in_data),
        .in_disc(in_disc), .in_capid(in_capid), .in_bc0(in_bc0), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
        .drop_cnt(drop_cnt), .capid_err_cnt(capid_err_cnt)
    );

    always #5 MClk = ~MClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // sample away from the rising edge: collect accepted words and check stall stability
    always @(negedge MClk) begin
        if (!BkPln_RST_N) hold_prev = 1'b0;
        else begin
            if (hold_prev) chk("hold", {14'd0, out_valid, out_sof, out_eof, out_data}, held);
            if (gap_watch && !out_valid) gaps++;
            if (out_valid && out_ready) rxq.push_back({out_sof, out_eof, out_data});
            hold_prev = out_valid && !out_ready;
            held = {14'd0, 1'b1, out_sof, out_eof, out_data};
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge MClk);
        #1;
    endtask

    task automatic do_reset;
        BkPln_RST_N = 1'b0;
        in_valid = 1'b0;
        in_bc0 = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        BkPln_RST_N = 1'b1;
        tick;
        rxq.delete();
        gaps = 0;
    endtask

    task automatic send(input logic [1:0] c, input logic b, input logic [DW-1:0] d, input logic [N_CH-1:0] s);
        in_valid = 1'b1;
        in_capid = c;
        in_bc0 = b;
        in_data = d;
        in_disc = s;
        tick;
        in_valid = 1'b0;
        in_bc0 = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 400 && rxq.size() < n; i++) tick;
    endtask

`ifdef QIE_FRAMER_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction
`endif

    task automatic expect_frame(input string tag, input logic [15:0] h, input logic [DW-1:0] d, input logic [N_CH-1:0] s);
        logic [17:0] e[$];
        logic [17:0] got;
        logic [15:0] c;
        e.push_back({2'b10, h});
        for (int i = 0; i < NW; i++) e.push_back({2'b00, d[i*16 +: 16]});
        e.push_back({2'b00, 16'(s)});
`ifdef QIE_FRAMER_CRC_EN
        c = 16'hFFFF;
        foreach (e[i]) c = crc_ref(c, e[i][15:0]);
        e.push_back({2'b00, c});
`else
        c = 16'h0;
`endif
        got = e.pop_back();
        got[16] = 1'b1;
        e.push_back(got);
        foreach (e[i]) begin
            got = (rxq.size() > 0) ? rxq.pop_front() : 18'h3FFFF;
            chk($sformatf("%s_w%0d", tag, i), {14'd0, got}, {14'd0, e[i]});
        end
    endtask

    logic [DW-1:0] d0;
    logic [15:0]   hdrs[6];

    initial begin
        // reset state
        do_reset;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sof_eof", {out_sof, out_eof}, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_caperr", capid_err_cnt, 0);

        // single frame with latency
        out_ready = 1'b1;
        d0 = 96'h0B0A09080706050403020100;
        send(2'd0, 1'b1, d0, 12'hA5A);
        tick;
        chk("lat_e1_valid", out_valid, 0);
        tick;
        chk("lat_e2_valid", out_valid, 1);
        chk("lat_e2_hdr", out_data, 16'hBC80);
        chk("lat_e2_sof", out_sof, 1);
        wait_rx(NWORDS);
        expect_frame("single", 16'hBC80, d0, 12'hA5A);
        chk("single_left", rxq.size(), 0);

        // CapID sequence 0,1,2,0(bc0),1
        do_reset;
        out_ready = 1'b1;
        hdrs = '{16'hBC00, 16'hBC09, 16'hBC12, 16'hBCC0, 16'hBC09, 16'h0};
        for (int k = 0; k < 5; k++) send(2'((k == 3) ? 0 : k % 3), k == 3, {3{32'hC0DE0000 | k}}, 12'(k * 291));
        wait_rx(5 * NWORDS);
        chk("cap_errcnt", capid_err_cnt, 1);
        chk("cap_dropcnt", drop_cnt, 0);
        for (int k = 0; k < 5; k++) expect_frame($sformatf("cap%0d", k), hdrs[k], {3{32'hC0DE0000 | k}}, 12'(k * 291));
        chk("cap_left", rxq.size(), 0);

        // overflow with downstream stalled
        do_reset;
        for (int k = 0; k < 6; k++) send(2'(k % 4), 1'b0, {6{16'h1100 + 16'(k)}}, 12'h800 | 12'(k));
        tick;
        tick;
        tick;
        chk("ovf_drop", drop_cnt, 1);
        chk("ovf_hold_hdr", {out_valid, out_sof, out_data}, {2'b11, 16'hBC00});
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick;
        send(2'd2, 1'b0, {6{16'h2266}}, 12'h066);
        wait_rx(6 * NWORDS);
        hdrs = '{16'hBC00, 16'hBC09, 16'hBC12, 16'hBC1B, 16'hBC04, 16'h0};
        for (int k = 0; k < 5; k++) expect_frame($sformatf("ovf%0d", k), hdrs[k], {6{16'h1100 + 16'(k)}}, 12'h800 | 12'(k));
        expect_frame("ovf6", 16'hBC36, {6{16'h2266}}, 12'h066);
        chk("ovf_drop_after", drop_cnt, 1);
        chk("ovf_left", rxq.size(), 0);

        // backpressure: ready toggles every cycle across two back-to-back frames
        do_reset;
        send(2'd0, 1'b0, 96'h123456789ABCDEF011223344, 12'h3C3);
        send(2'd1, 1'b0, 96'hFEDCBA987654321055667788, 12'hC3C);
        for (int i = 0; i < 200 && rxq.size() < 2 * NWORDS; i++) begin
            tick;
            out_ready = ~out_ready;
            if (out_valid) gap_watch = 1'b1;
        end
        gap_watch = 1'b0;
        chk("bp_gaps", gaps, 0);
        expect_frame("bp0", 16'hBC00, 96'h123456789ABCDEF011223344, 12'h3C3);
        expect_frame("bp1", 16'hBC09, 96'hFEDCBA987654321055667788, 12'hC3C);
        chk("bp_left", rxq.size(), 0);

        // reset in the middle of a frame
        do_reset;
        out_ready = 1'b1;
        send(2'd2, 1'b0, {12{8'h5A}}, 12'h111);
        send(2'd0, 1'b0, {12{8'hA5}}, 12'h222);
        for (int i = 0; i < 50 && rxq.size() < 3; i++) tick;
        chk("mid_caperr_pre", capid_err_cnt, 1);
        chk("mid_word3_valid", out_valid, 1);
        BkPln_RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_caperr", capid_err_cnt, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        tick;
        BkPln_RST_N = 1'b1;
        rxq.delete();
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("mid_idle%0d", i), out_valid, 0);
        end
        send(2'd3, 1'b0, {12{8'h3C}}, 12'h333);
        wait_rx(NWORDS);
        expect_frame("mid_after", 16'hBC18, {12{8'h3C}}, 12'h333);
        chk("mid_caperr_post", capid_err_cnt, 0);
        chk("mid_left", rxq.size(), 0);

`ifdef QIE_FRAMER_CRC_EN
        // CRC word on an all-zero frame
        do_reset;
        out_ready = 1'b1;
        send(2'd1, 1'b0, '0, '0);
        wait_rx(NWORDS);
        chk("crc_len", rxq.size(), 9);
        expect_frame("crc", 16'hBC08, '0, '0);
        chk("crc_left", rxq.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
